operand_fetch: RTL and testbench
================================

Name: operand_fetch

Overview:
- Read-side initiator for the 32x32 register file (registered reads, one-cycle latency, no internal write-to-read bypass).
- Accepts decoded instructions (rs1, rs2, payload) over valid/ready and drives the file's two read addresses.
- Collects read data one cycle later and forwards pending writeback values.
- Presents complete operands to execute over a valid/ready handshake, holding them stable and coherent with later writebacks while stalled.

Parameters:
DATA_W, 32, register/operand width
ADDR_W, 5, register index width (register 0 hardwired zero)
PAYLOAD_W, 32, opaque side-band carried with the instruction (pc, decoded op)

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous, active-low reset
in_valid  in  1  upstream instruction valid
in_ready  out  1  block can accept this cycle
in_rs1  in  ADDR_W  source register A index
in_rs2  in  ADDR_W  source register B index
in_payload  in  PAYLOAD_W  side-band
rf_read_a_address  out  ADDR_W  to register file read port A
rf_read_b_address  out  ADDR_W  to register file read port B
rf_read_a_data  in  DATA_W  register file read data A (registered, 1 cycle after address)
rf_read_b_data  in  DATA_W  register file read data B
wb_enable  in  1  writeback snoop: same signal driving register file write enable
wb_address  in  ADDR_W  writeback index
wb_data  in  DATA_W  writeback data
out_valid  out  1  operands valid
out_ready  in  1  execute accepts
out_rs1_data  out  DATA_W  operand A
out_rs2_data  out  DATA_W  operand B
out_payload  out  PAYLOAD_W  side-band of presented instruction

Behaviour:
- Operand rule:
  - The presented operand equals the architectural register value including every write committed at or before the current edge.
  - It also includes a write asserted in the current cycle, forwarded combinationally.
  - Index 0 always yields 0 and is never forwarded.
- rf_read_*_address = in_rs1/in_rs2 combinationally, every cycle. The file samples them at the accept edge.
- Accept: in_valid && in_ready at an edge. The block latches rs1, rs2 and payload.
- Accept-edge write capture:
  - If wb_enable && wb_address==rs && rs!=0 at the accept edge, latch a bypass flag and wb_data per operand.
  - Reason: the file returns the pre-write value for that edge.
- FSM states: IDLE, READ, HOLD.
  - IDLE: out_valid=0, in_ready=1. Accept -> READ.
  - READ:
    - out_valid=1.
    - operand = fwd(wb, bypass_flag ? bypass_val : rf_read_data).
    - out_ready=1 -> IDLE, or READ if a new instruction is accepted the same cycle.
    - out_ready=0 -> HOLD; capture the presented operands, including any same-cycle write, into hold registers.
  - HOLD:
    - out_valid=1; operand = fwd(wb, hold).
    - Hold registers are updated every cycle a matching nonzero write occurs.
    - out_ready=1 -> IDLE, or READ if a new accept happens the same cycle.
- in_ready = (state==IDLE) || (out_valid && out_ready). This is a combinational out_ready->in_ready path. Throughput is 1 instruction/cycle with 1-cycle latency from accept to out_valid.
- fwd(wb, x): if wb_enable && wb_address==rs && rs!=0 then wb_data else x. Computed per operand independently. rs1==rs2 is legal.
- Output stability: out_valid, once high, stays high until handshake. out_payload is stable and operand values change only through forwarding.
- Reset (reset_n low, any time including mid-transfer):
  - state=IDLE, out_valid=0, in_ready=1 after release.
  - Hold registers, latched indices, bypass flags, payload and outputs = 0.
  - In-flight instruction is dropped.

Test Plan:
- Reset then file x5=0x11; accept rs1=5,rs2=0, payload=0xA5, out_ready=1 -> next cycle out_valid=1, rs1_data=0x11, rs2_data=0, payload=0xA5; following cycle out_valid=0.
- Accept rs1=7 in same cycle as wb x7<=0x2222 -> presented rs1_data=0x2222, not the stale file value.
- Stall: out_ready=0 for 3 cycles after READ, wb x3<=0xBEEF during HOLD with rs2=3 -> rs2_data becomes 0xBEEF from that cycle on and is retained; payload unchanged; in_ready=0 until handshake.
- wb_enable with wb_address=0, data 0xFFFF_FFFF while presenting rs1=0 -> rs1_data stays 0.
- Back-to-back: in_valid=1 for 4 instructions with out_ready=1 -> 4 consecutive out_valid cycles, in order, no bubbles.
- reset_n low asynchronously during HOLD -> out_valid drops immediately; after release in_ready=1 and the held instruction never appears.

Source files
------------

// File: rtl/operand_fetch_if.sv
// rtl/operand_fetch_if.sv - handshake and register-file bus bundle for operand_fetch
//   upstream:   in_valid, in_ready, in_rs1, in_rs2, in_payload
//   file read:  rf_read_a/b_address (out of block), rf_read_a/b_data (into block)
//   writeback:  wb_enable, wb_address, wb_data (snooped)
//   downstream: out_valid, out_ready, out_rs1_data, out_rs2_data, out_payload
//   modport slave is the operand_fetch side, modport master is its environment.
interface operand_fetch_if #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int PAYLOAD_W = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [ADDR_W-1:0]    in_rs1;
    logic [ADDR_W-1:0]    in_rs2;
    logic [PAYLOAD_W-1:0] in_payload;
    logic [ADDR_W-1:0]    rf_read_a_address;
    logic [ADDR_W-1:0]    rf_read_b_address;
    logic [DATA_W-1:0]    rf_read_a_data;
    logic [DATA_W-1:0]    rf_read_b_data;
    logic                 wb_enable;
    logic [ADDR_W-1:0]    wb_address;
    logic [DATA_W-1:0]    wb_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [DATA_W-1:0]    out_rs1_data;
    logic [DATA_W-1:0]    out_rs2_data;
    logic [PAYLOAD_W-1:0] out_payload;

    modport slave (
        input  in_valid, in_rs1, in_rs2, in_payload,
        output in_ready,
        output rf_read_a_address, rf_read_b_address,
        input  rf_read_a_data, rf_read_b_data,
        input  wb_enable, wb_address, wb_data,
        output out_valid, out_rs1_data, out_rs2_data, out_payload,
        input  out_ready
    );

    modport master (
        output in_valid, in_rs1, in_rs2, in_payload,
        input  in_ready,
        input  rf_read_a_address, rf_read_b_address,
        output rf_read_a_data, rf_read_b_data,
        output wb_enable, wb_address, wb_data,
        input  out_valid, out_rs1_data, out_rs2_data, out_payload,
        output out_ready
    );
endinterface

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - register-file read initiator presenting forwarded operands to execute
//   clk      : clock, all state on rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : operand_fetch_if.slave (upstream accept, file read ports, writeback snoop,
//              downstream operand handshake)
module operand_fetch #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int PAYLOAD_W = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    operand_fetch_if.slave bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [1:0]           state;
    logic [ADDR_W-1:0]    rs1_q, rs2_q;
    logic [PAYLOAD_W-1:0] payload_q;
    logic                 byp1_q, byp2_q;
    logic [DATA_W-1:0]    bypv1_q, bypv2_q;
    logic [DATA_W-1:0]    hold1_q, hold2_q;

    logic              accept;
    logic              acc_hit1, acc_hit2;
    logic              wb_hit1, wb_hit2;
    logic [DATA_W-1:0] base1, base2;
    logic [DATA_W-1:0] op1, op2;

    // File samples the address at the accept edge, so it simply follows the inputs.
    assign bus.rf_read_a_address = bus.in_rs1;
    assign bus.rf_read_b_address = bus.in_rs2;

    assign bus.out_valid = (state != ST_IDLE);
    assign bus.in_ready  = (state == ST_IDLE) || (bus.out_valid && bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;

    // A write at the accept edge is invisible in the file's read data for that edge.
    assign acc_hit1 = bus.wb_enable && (bus.wb_address == bus.in_rs1) && (bus.in_rs1 != '0);
    assign acc_hit2 = bus.wb_enable && (bus.wb_address == bus.in_rs2) && (bus.in_rs2 != '0);

    assign wb_hit1 = bus.wb_enable && (bus.wb_address == rs1_q) && (rs1_q != '0);
    assign wb_hit2 = bus.wb_enable && (bus.wb_address == rs2_q) && (rs2_q != '0);

    always_comb begin
        base1 = '0;
        base2 = '0;
        if (state == ST_HOLD) begin
            base1 = hold1_q;
            base2 = hold2_q;
        end else if (state == ST_READ) begin
            base1 = byp1_q ? bypv1_q : bus.rf_read_a_data;
            base2 = byp2_q ? bypv2_q : bus.rf_read_b_data;
        end
    end

    // Index 0 is forced to zero regardless of what the file or writeback show.
    assign op1 = (rs1_q == '0) ? '0 : (wb_hit1 ? bus.wb_data : base1);
    assign op2 = (rs2_q == '0) ? '0 : (wb_hit2 ? bus.wb_data : base2);

    assign bus.out_rs1_data = bus.out_valid ? op1 : '0;
    assign bus.out_rs2_data = bus.out_valid ? op2 : '0;
    assign bus.out_payload  = payload_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            rs1_q     <= '0;
            rs2_q     <= '0;
            payload_q <= '0;
            byp1_q    <= 1'b0;
            byp2_q    <= 1'b0;
            bypv1_q   <= '0;
            bypv2_q   <= '0;
            hold1_q   <= '0;
            hold2_q   <= '0;
        end else begin
            if (accept) begin
                rs1_q     <= bus.in_rs1;
                rs2_q     <= bus.in_rs2;
                payload_q <= bus.in_payload;
                byp1_q    <= acc_hit1;
                byp2_q    <= acc_hit2;
                bypv1_q   <= bus.wb_data;
                bypv2_q   <= bus.wb_data;
            end
            // While stalled, the hold registers track the presented (forwarded) value,
            // so any write committed during the stall is retained.
            if (bus.out_valid && !bus.out_ready) begin
                hold1_q <= op1;
                hold2_q <= op2;
            end
            case (state)
                ST_IDLE: state <= accept ? ST_READ : ST_IDLE;
                ST_READ, ST_HOLD: begin
                    if (bus.out_ready) state <= accept ? ST_READ : ST_IDLE;
                    else               state <= ST_HOLD;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - self-checking bench for operand_fetch with register-file model
module tb_operand_fetch;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    operand_fetch_if #(.DATA_W(32), .ADDR_W(5), .PAYLOAD_W(32)) bus ();

    operand_fetch #(.DATA_W(32), .ADDR_W(5), .PAYLOAD_W(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    // Register file: registered reads returning the pre-write value, x0 never written.
    logic [31:0] regs [32];
    always @(posedge clk) begin
        bus.rf_read_a_data <= regs[bus.rf_read_a_address];
        bus.rf_read_b_data <= regs[bus.rf_read_b_address];
        if (bus.wb_enable && bus.wb_address != 5'd0) regs[bus.wb_address] <= bus.wb_data;
    end

    int checks = 0;
    int failures = 0;

    // Reference: at most one instruction presented at a time.
    logic        have_item = 1'b0;
    logic [4:0]  m_rs1, m_rs2;
    logic [31:0] m_payload;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Architectural value visible this cycle, including a same-cycle write.
    function automatic logic [31:0] arch(input logic [4:0] rs);
        if (rs == 5'd0) return 32'd0;
        if (bus.wb_enable && bus.wb_address == rs) return bus.wb_data;
        return regs[rs];
    endfunction

    // One clock cycle: drive inputs, check outputs against the model, advance model.
    task automatic step(input logic iv, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [31:0] pay, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic ordy);
        logic exp_ready;
        @(negedge clk);
        bus.in_valid   = iv;
        bus.in_rs1     = r1;
        bus.in_rs2     = r2;
        bus.in_payload = pay;
        bus.wb_enable  = we;
        bus.wb_address = wa;
        bus.wb_data    = wd;
        bus.out_ready  = ordy;
        #1;
        exp_ready = !have_item || ordy;
        chk("out_valid", {31'd0, bus.out_valid}, {31'd0, have_item});
        chk("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_ready});
        chk("rf_addr_a", {27'd0, bus.rf_read_a_address}, {27'd0, r1});
        if (have_item) begin
            chk("rs1_data", bus.out_rs1_data, arch(m_rs1));
            chk("rs2_data", bus.out_rs2_data, arch(m_rs2));
            chk("payload", bus.out_payload, m_payload);
        end
        if (have_item && ordy) have_item = 1'b0;
        if (iv && exp_ready) begin
            have_item = 1'b1;
            m_rs1 = r1;
            m_rs2 = r2;
            m_payload = pay;
        end
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 5'd0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ordy);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        step(1'b0, 5'd0, 5'd0, 32'd0, 1'b1, a, d, 1'b1);
    endtask

    int vcount;

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        bus.in_valid = 0; bus.in_rs1 = 0; bus.in_rs2 = 0; bus.in_payload = 0;
        bus.wb_enable = 0; bus.wb_address = 0; bus.wb_data = 0; bus.out_ready = 0;
        #1;
        chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("reset_payload", bus.out_payload, 32'd0);
        chk("reset_rs1_data", bus.out_rs1_data, 32'd0);
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;

        // Basic read of x5
        wr(5'd5, 32'h11);
        step(1'b1, 5'd5, 5'd0, 32'hA5, 1'b0, 5'd0, 32'd0, 1'b1);
        idle(1'b1);
        chk("t1_rs1", bus.out_rs1_data, 32'h11);
        chk("t1_payload", bus.out_payload, 32'hA5);
        idle(1'b1);
        chk("t1_drop", {31'd0, bus.out_valid}, 32'd0);

        // Write at accept edge must be bypassed
        wr(5'd7, 32'h1234);
        step(1'b1, 5'd7, 5'd7, 32'hB0, 1'b1, 5'd7, 32'h2222, 1'b1);
        idle(1'b1);
        chk("t2_rs1", bus.out_rs1_data, 32'h2222);
        chk("t2_rs2", bus.out_rs2_data, 32'h2222);

        // Stall with write during HOLD
        wr(5'd3, 32'h3333);
        step(1'b1, 5'd5, 5'd3, 32'hC1, 1'b0, 5'd0, 32'd0, 1'b1);
        idle(1'b0);
        step(1'b1, 5'd9, 5'd9, 32'hDD, 1'b1, 5'd3, 32'hBEEF, 1'b0);
        chk("t3_fwd", bus.out_rs2_data, 32'hBEEF);
        idle(1'b0);
        chk("t3_kept", bus.out_rs2_data, 32'hBEEF);
        chk("t3_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("t3_payload", bus.out_payload, 32'hC1);
        idle(1'b1);

        // x0 never forwarded
        step(1'b1, 5'd0, 5'd5, 32'hE0, 1'b0, 5'd0, 32'd0, 1'b1);
        step(1'b0, 5'd0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1);
        chk("t4_x0", bus.out_rs1_data, 32'd0);

        // Back-to-back, no bubbles
        vcount = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 5'(i + 1), 5'(i + 2), 32'h100 + i, 1'b0, 5'd0, 32'd0, 1'b1);
            if (i > 0) vcount += bus.out_valid;
        end
        idle(1'b1);
        vcount += bus.out_valid;
        chk("t5_b2b", vcount, 32'd4);
        chk("t5_last_payload", bus.out_payload, 32'h103);

        // Asynchronous reset during HOLD
        step(1'b1, 5'd5, 5'd3, 32'hF00D, 1'b0, 5'd0, 32'd0, 1'b1);
        idle(1'b0);
        idle(1'b0);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_async_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("t6_payload_clr", bus.out_payload, 32'd0);
        have_item = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        idle(1'b0);
        idle(1'b1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                 1'($urandom_range(0, 2) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
